// File: rtl/lstm_pkg.sv
// Shared types and sizing for the LSTM gate scheduling slice.
// Gate bank selects, scheduler states and fixed-point widths.
package lstm_pkg;

  localparam int HIDDEN_SZ = 16;
  localparam int QN = 6;
  localparam int QM = 11;
  localparam int MAX_SEQ = 64;

  localparam int BITWIDTH = QN + QM + 1;
  localparam int LAYER_BITWIDTH = BITWIDTH * HIDDEN_SZ;
  localparam int TS_BITS = $clog2(MAX_SEQ + 1);

  localparam logic [1:0] GATE_I = 2'd0;
  localparam logic [1:0] GATE_F = 2'd1;
  localparam logic [1:0] GATE_O = 2'd2;
  localparam logic [1:0] GATE_G = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_X,
    S_ISSUE,
    S_WAIT_GATE,
    S_CELL_START,
    S_CELL_WAIT,
    S_STEP_END,
    S_DONE
  } state_t;

  function automatic logic is_last_gate(
    input logic [1:0] sel
  );
    return sel == GATE_G;
  endfunction

endpackage

// File: rtl/lstm_gate_capture.sv
// Four-entry register bank holding the latest i/f/o/g gate results.
// One vector is written per enabled cycle, chosen by the gate select.
module lstm_gate_capture
  import lstm_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      we,
  input  logic [1:0]                sel,
  input  logic [LAYER_BITWIDTH-1:0] din,
  output logic [LAYER_BITWIDTH-1:0] i_vec,
  output logic [LAYER_BITWIDTH-1:0] f_vec,
  output logic [LAYER_BITWIDTH-1:0] o_vec,
  output logic [LAYER_BITWIDTH-1:0] g_vec
);

  always_ff @(posedge clock) begin
    if (reset) begin
      i_vec <= '0;
      f_vec <= '0;
      o_vec <= '0;
      g_vec <= '0;
    end else if (we) begin
      unique case (sel)
        GATE_I: i_vec <= din;
        GATE_F: f_vec <= din;
        GATE_O: o_vec <= din;
        GATE_G: g_vec <= din;
      endcase
    end
  end

endmodule

// File: rtl/lstm_gate_scheduler.sv
// Steps the shared gate datapath through i/f/o/g, then the cell
// update, once per timestep; all outputs decode from registered state.
module lstm_gate_scheduler
  import lstm_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [TS_BITS-1:0]        seq_len,
  input  logic                      abort,
  output logic                      x_load,
  output logic [1:0]                gate_sel,
  output logic                      gate_begin,
  input  logic                      gate_ready,
  input  logic [LAYER_BITWIDTH-1:0] gate_output,
  output logic [LAYER_BITWIDTH-1:0] i_vec,
  output logic [LAYER_BITWIDTH-1:0] f_vec,
  output logic [LAYER_BITWIDTH-1:0] o_vec,
  output logic [LAYER_BITWIDTH-1:0] g_vec,
  output logic                      cell_start,
  input  logic                      cell_done,
  output logic [TS_BITS-1:0]        timestep,
  output logic                      busy,
  output logic                      step_done,
  output logic                      done
);

  state_t             state_q;
  state_t             state_d;
  logic [1:0]         gate_sel_q;
  logic [1:0]         gate_sel_d;
  logic [TS_BITS-1:0] timestep_q;
  logic [TS_BITS-1:0] timestep_d;
  logic [TS_BITS-1:0] seq_len_q;
  logic [TS_BITS-1:0] seq_len_d;
  logic [TS_BITS-1:0] ts_next;
  logic               cap_we;

  assign ts_next = timestep_q + TS_BITS'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      gate_sel_q <= GATE_I;
      timestep_q <= '0;
      seq_len_q  <= '0;
    end else begin
      state_q    <= state_d;
      gate_sel_q <= gate_sel_d;
      timestep_q <= timestep_d;
      seq_len_q  <= seq_len_d;
    end
  end

  // Abort overrides everything, including a capture in the same cycle.
  always_comb begin
    state_d    = state_q;
    gate_sel_d = gate_sel_q;
    timestep_d = timestep_q;
    seq_len_d  = seq_len_q;
    cap_we     = 1'b0;
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            gate_sel_d = GATE_I;
            timestep_d = '0;
            seq_len_d  = seq_len;
            if (seq_len == '0) state_d = S_DONE;
            else               state_d = S_LOAD_X;
          end
        end
        S_LOAD_X: state_d = S_ISSUE;
        S_ISSUE:  state_d = S_WAIT_GATE;
        S_WAIT_GATE: begin
          if (gate_ready) begin
            cap_we = 1'b1;
            if (is_last_gate(gate_sel_q)) begin
              state_d = S_CELL_START;
            end else begin
              gate_sel_d = gate_sel_q + 2'd1;
              state_d    = S_ISSUE;
            end
          end
        end
        S_CELL_START: state_d = S_CELL_WAIT;
        S_CELL_WAIT: begin
          if (cell_done) state_d = S_STEP_END;
        end
        S_STEP_END: begin
          if (ts_next == seq_len_q) begin
            state_d = S_DONE;
          end else begin
            timestep_d = ts_next;
            gate_sel_d = GATE_I;
            state_d    = S_LOAD_X;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign x_load     = state_q == S_LOAD_X;
  assign gate_begin = state_q == S_ISSUE;
  assign cell_start = state_q == S_CELL_START;
  assign step_done  = state_q == S_STEP_END;
  assign done       = state_q == S_DONE;
  assign busy       = state_q != S_IDLE;
  assign gate_sel   = gate_sel_q;
  assign timestep   = timestep_q;

  lstm_gate_capture u_capture (
    .clock (clock),
    .reset (reset),
    .we    (cap_we),
    .sel   (gate_sel_q),
    .din   (gate_output),
    .i_vec (i_vec),
    .f_vec (f_vec),
    .o_vec (o_vec),
    .g_vec (g_vec)
  );

endmodule

// File: tb/tb_lstm_gate_scheduler.sv
// Randomized bench: responds to gate/cell requests with random delays
// and compares event order, latencies and captured vectors to a model.
module tb_lstm_gate_scheduler;
  import lstm_pkg::*;

  localparam int LW = LAYER_BITWIDTH;

  logic               clock = 1'b0;
  logic               reset;
  logic               start;
  logic [TS_BITS-1:0] seq_len;
  logic               abort;
  logic               x_load;
  logic [1:0]         gate_sel;
  logic               gate_begin;
  logic               gate_ready;
  logic [LW-1:0]      gate_output;
  logic [LW-1:0]      i_vec;
  logic [LW-1:0]      f_vec;
  logic [LW-1:0]      o_vec;
  logic [LW-1:0]      g_vec;
  logic               cell_start;
  logic               cell_done;
  logic [TS_BITS-1:0] timestep;
  logic               busy;
  logic               step_done;
  logic               done;

  logic [LW-1:0] exp_vec [4];
  int checks = 0;
  int errors = 0;

  lstm_gate_scheduler dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .seq_len     (seq_len),
    .abort       (abort),
    .x_load      (x_load),
    .gate_sel    (gate_sel),
    .gate_begin  (gate_begin),
    .gate_ready  (gate_ready),
    .gate_output (gate_output),
    .i_vec       (i_vec),
    .f_vec       (f_vec),
    .o_vec       (o_vec),
    .g_vec       (g_vec),
    .cell_start  (cell_start),
    .cell_done   (cell_done),
    .timestep    (timestep),
    .busy        (busy),
    .step_done   (step_done),
    .done        (done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rand_vec(output logic [LW-1:0] v);
    for (int w = 0; w < LW / 32; w++) v[w*32 +: 32] = $urandom;
  endtask

  // Model: a step costs LOAD_X + CELL_START + STEP_END, plus (1 + d)
  // per gate and c for the cell, where d/c are the response delays.
  task automatic run_seq(input int len, input int dmin, input int dmax,
                         input int cmin, input int cmax, input bit fixed,
                         input bit noise, input string tag,
                         output int total);
    int gd, cd, step, eg, first_x, x_cyc, lat, tot, nx, nb, nc, budget;
    bit fin;
    logic [7:0] pat;
    logic [LW-1:0] val, junk;
    logic [LW-1:0] got [4];
    gd = 0; cd = 0; step = 0; eg = 0; first_x = -1; x_cyc = 0;
    lat = 0; tot = 0; nx = 0; nb = 0; nc = 0; fin = 0;
    val = '0; total = -1;
    budget = 10 + len * (4 * (dmax + 1) + cmax + 3);
    seq_len = TS_BITS'(len);
    start = 1'b1;
    for (int cyc = 0; cyc < budget && !fin; cyc++) begin
      tick();
      start = 1'b0;
      gate_ready = 1'b0;
      cell_done = 1'b0;
      if (noise) seq_len = TS_BITS'($urandom);
      if (x_load) begin
        nx++;
        x_cyc = cyc;
        if (first_x < 0) first_x = cyc;
        lat = 3;
        eg = 0;
      end
      if (gate_begin) begin
        nb++;
        checks++;
        if (gate_sel !== 2'(eg)) begin
          errors++;
          $display("FAIL %s sel_at_begin got %0d want %0d", tag, gate_sel, eg);
        end
        gd = $urandom_range(dmax, dmin);
        lat += 1 + gd;
        if (fixed) begin
          pat = 8'(8'h11 * (eg + 1));
          val = {(LW / 8){pat}};
        end else begin
          rand_vec(val);
        end
      end else if (gd > 0) begin
        gd--;
        if (noise) start = 1'($urandom);
        if (gd == 0) begin
          checks++;
          if (gate_sel !== 2'(eg)) begin
            errors++;
            $display("FAIL %s sel_at_capture got %0d want %0d", tag, gate_sel, eg);
          end
          gate_ready = 1'b1;
          gate_output = val;
          exp_vec[eg & 3] = val;
          eg++;
        end
      end
      if (cell_start) begin
        nc++;
        cd = $urandom_range(cmax, cmin);
        lat += cd;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          cell_done = 1'b1;
        end else if (noise) begin
          gate_ready = 1'($urandom);
          rand_vec(junk);
          gate_output = junk;
        end
      end
      if (step_done) begin
        checks++;
        if (timestep !== TS_BITS'(step)) begin
          errors++;
          $display("FAIL %s timestep got %0d want %0d", tag, timestep, step);
        end
        checks++;
        if (cyc - x_cyc + 1 != lat) begin
          errors++;
          $display("FAIL %s step_latency got %0d want %0d", tag, cyc - x_cyc + 1, lat);
        end
        tot += lat;
        step++;
      end
      if (done) begin
        fin = 1'b1;
        checks++;
        if (step != len || nx != len || nb != 4 * len || nc != len) begin
          errors++;
          $display("FAIL %s event_counts got steps=%0d x=%0d begin=%0d cell=%0d want len=%0d",
                   tag, step, nx, nb, nc, len);
        end
        if (len == 0) begin
          total = cyc;
          checks++;
          if (cyc > 1) begin
            errors++;
            $display("FAIL %s zero_len_done got cycle %0d want <=1", tag, cyc);
          end
        end else begin
          total = cyc - first_x;
          checks++;
          if (total != tot) begin
            errors++;
            $display("FAIL %s run_latency got %0d want %0d", tag, total, tot);
          end
          checks++;
          if (timestep !== TS_BITS'(len - 1)) begin
            errors++;
            $display("FAIL %s final_timestep got %0d want %0d", tag, timestep, len - 1);
          end
        end
        got = '{i_vec, f_vec, o_vec, g_vec};
        for (int k = 0; k < 4; k++) begin
          checks++;
          if (got[k] !== exp_vec[k]) begin
            errors++;
            $display("FAIL %s vec%0d got %h want %h", tag, k, got[k], exp_vec[k]);
          end
        end
      end
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL %s timeout got no done want done within %0d", tag, budget);
    end
    start = 1'b0;
    gate_ready = 1'b0;
    cell_done = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after got busy=%b done=%b want 0 0", tag, busy, done);
    end
  endtask

  task automatic check_zero(input string tag);
    logic [LW-1:0] got [4];
    checks++;
    if ({busy, done, x_load, gate_begin, cell_start, step_done} !== 6'b0 ||
        gate_sel !== 2'd0 || timestep !== '0) begin
      errors++;
      $display("FAIL %s ctrl got %b sel=%0d ts=%0d want all 0", tag,
               {busy, done, x_load, gate_begin, cell_start, step_done}, gate_sel, timestep);
    end
    got = '{i_vec, f_vec, o_vec, g_vec};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k] !== '0) begin
        errors++;
        $display("FAIL %s vec%0d got %h want 0", tag, k, got[k]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    check_zero("reset");
    for (int k = 0; k < 4; k++) exp_vec[k] = '0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_step();
    int t;
    run_seq(1, 3, 3, 1, 1, 1'b1, 1'b0, "single", t);
  endtask

  task automatic test_min_latency();
    int t;
    run_seq(3, 1, 1, 1, 1, 1'b0, 1'b0, "minlat", t);
    checks++;
    if (t != 36) begin
      errors++;
      $display("FAIL minlat load_to_done got %0d want 36", t);
    end
  endtask

  task automatic test_zero_len();
    int t;
    run_seq(0, 1, 1, 1, 1, 1'b0, 1'b0, "zero", t);
  endtask

  task automatic test_spurious();
    int t;
    run_seq(4, 1, 4, 2, 5, 1'b0, 1'b1, "spurious", t);
  endtask

  task automatic test_abort();
    logic [LW-1:0] v;
    logic [LW-1:0] got [4];
    int t;
    start = 1'b1;
    seq_len = TS_BITS'(2);
    tick();
    start = 1'b0;
    for (int g = 0; g < 2; g++) begin
      tick();
      gate_ready = 1'b0;
      tick();
      rand_vec(v);
      gate_ready = 1'b1;
      gate_output = v;
      exp_vec[g] = v;
    end
    tick();
    gate_ready = 1'b0;
    checks++;
    if (gate_begin !== 1'b1 || gate_sel !== 2'd2) begin
      errors++;
      $display("FAIL abort pre got begin=%b sel=%0d want 1 2", gate_begin, gate_sel);
    end
    tick();
    rand_vec(v);
    abort = 1'b1;
    gate_ready = 1'b1;
    gate_output = v;
    tick();
    abort = 1'b0;
    gate_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || step_done !== 1'b0) begin
      errors++;
      $display("FAIL abort idle got busy=%b done=%b step=%b want 0 0 0", busy, done, step_done);
    end
    got = '{i_vec, f_vec, o_vec, g_vec};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k] !== exp_vec[k]) begin
        errors++;
        $display("FAIL abort vec%0d got %h want %h", k, got[k], exp_vec[k]);
      end
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort late got done=%b busy=%b want 0 0", done, busy);
    end
    run_seq(1, 1, 2, 1, 2, 1'b0, 1'b0, "after_abort", t);
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1;
    seq_len = TS_BITS'(1);
    tick();
    start = 1'b0;
    for (int g = 0; g < 4; g++) begin
      tick();
      gate_ready = 1'b0;
      tick();
      gate_ready = 1'b1;
      rand_vec(gate_output);
    end
    tick();
    gate_ready = 1'b0;
    checks++;
    if (cell_start !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid cell_start got %b want 1", cell_start);
    end
    tick();
    reset = 1'b1;
    tick();
    check_zero("rst_mid");
    for (int k = 0; k < 4; k++) exp_vec[k] = '0;
    reset = 1'b0;
    cell_done = 1'b1;
    tick();
    cell_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({busy, step_done, done, cell_start} !== 4'b0) begin
        errors++;
        $display("FAIL rst_mid after got %b want 0000", {busy, step_done, done, cell_start});
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int t;
    for (int r = 0; r < 3; r++) begin
      run_seq($urandom_range(5, 1), 1, 3, 1, 3, 1'b0, 1'b0, "b2b", t);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    seq_len = '0;
    abort = 1'b0;
    gate_ready = 1'b0;
    gate_output = '0;
    cell_done = 1'b0;
    test_reset();
    test_single_step();
    test_min_latency();
    test_zero_len();
    test_spurious();
    test_abort();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
